regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning number of architectural registers (power of two, 4..64); AW = $clog2(NREGS).
REQ-003 SHALL have parameter NRP, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-005 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports: raddr  in  NRP*AW  packed read addresses, port k at [k*AW +: AW]; rdata  out  NRP*XLEN  packed read data.
REQ-007 SHALL have ports: we0  in  1; waddr0  in  AW; wdata0  in  XLEN  (write port 0); we1  in  1; waddr1  in  AW; wdata1  in  XLEN  (write port 1).
REQ-008 SHALL have ports: iss_valid  in  1  issue strobe; iss_rd  in  AW  destination being issued; pending  out  NREGS  per-register scoreboard bits.
REQ-009 SHALL have port: ready  out  1  high once the post-reset clear sequence has completed.

Function
REQ-010 SHALL implement a two-state FSM, CLEAR and RUN; rst forces CLEAR with clear counter = 0.
REQ-011 In CLEAR, SHALL write zero to the entry at the counter index each cycle, increment the counter, and move to RUN on the cycle after index NREGS-1 is written (NREGS cycles total).
REQ-012 ready SHALL be 0 in CLEAR and 1 in RUN; ready SHALL be registered.
REQ-013 In CLEAR, SHALL ignore we0, we1 and iss_valid, and SHALL drive all rdata lanes to 0.
REQ-014 In RUN, SHALL write wdata0 to waddr0 on a clock edge where we0=1, and wdata1 to waddr1 on a clock edge where we1=1.
REQ-015 When both write ports hit the same address in one cycle, port 1 SHALL win.
REQ-016 With ZERO_REG=1, writes to address 0 SHALL be discarded, rdata for address 0 SHALL be 0, and pending[0] SHALL stay 0.
REQ-017 Each rdata lane SHALL be combinational from raddr and array contents, with zero-cycle read latency.
REQ-018 In RUN, iss_valid=1 SHALL set pending[iss_rd] at the next edge.
REQ-019 A write on either port SHALL clear pending[waddr] at the next edge.
REQ-020 When a set and a clear of the same pending bit occur in one cycle, the set SHALL win.
REQ-021 Addresses SHALL be AW bits wide and used unmodified; no out-of-range handling is required.

Reset
REQ-022 rst SHALL asynchronously force state=CLEAR, counter=0, ready=0 and pending=0; rdata SHALL read 0 immediately.
REQ-023 rst asserted mid-CLEAR or mid-RUN SHALL restart the full NREGS-cycle clear sequence after deassertion.
REQ-024 Array storage SHALL NOT be reset directly; it SHALL be zeroed only by the clear sequence.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN, when defined, SHALL make a read lane whose raddr matches an enabled RUN-state write in the same cycle return that write's data (port 1 over port 0), excluding address 0 when ZERO_REG=1.
REQ-026 Without REGFILE_BYPASS_EN, SHALL return the pre-write array value in the write cycle and the new value from the next cycle.

Verification
REQ-027 Scenario: release rst, NREGS=32 -> ready=0 for exactly 32 cycles, then 1; every register reads 0.
REQ-028 Scenario: RUN, we0=1 waddr0=5 wdata0=0xDEADBEEF and we1=1 waddr1=5 wdata1=0x12345678 -> next cycle, raddr=5 reads 0x12345678.
REQ-029 Scenario: write 0xFFFFFFFF to address 0 with ZERO_REG=1 -> rdata=0; iss_valid with iss_rd=0 -> pending[0]=0.
REQ-030 Scenario: iss_valid iss_rd=7, then we0 waddr0=7 while iss_valid iss_rd=7 again -> pending[7] remains 1; a later lone write -> pending[7]=0.
REQ-031 Scenario: with REGFILE_BYPASS_EN, write 0xA5A5A5A5 to address 3 while raddr=3 -> same-cycle rdata=0xA5A5A5A5; without the macro -> old value.
REQ-032 Scenario: assert rst at clear index 10 and during RUN with pending bits set -> pending=0 and ready=0, then a full 32-cycle clear.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus interface for regfile_mp: read ports, two write ports, issue strobe,
// scoreboard and ready. The master drives requests; the slave (register file)
// returns read data, the pending bits and ready.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic                we0;
  logic [AW-1:0]       waddr0;
  logic [XLEN-1:0]     wdata0;
  logic                we1;
  logic [AW-1:0]       waddr1;
  logic [XLEN-1:0]     wdata1;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic [NREGS-1:0]    pending;
  logic                ready;

  modport master (
    output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, iss_valid, iss_rd,
    input  rdata, pending, ready
  );

  modport slave (
    input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, iss_valid, iss_rd,
    output rdata, pending, ready
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-register pending scoreboard.
// After reset a CLEAR sweep zeroes one entry per cycle (NREGS cycles), then
// the block enters RUN and raises ready. Write port 1 wins on address
// collisions; a scoreboard set wins over a clear of the same bit.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to matching read lanes.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [NREGS-1:0] pending_q, pending_d;

  logic [XLEN-1:0]  mem [NREGS];

  logic             clr_en;
  logic             wr0_en;
  logic             wr1_en;

  // Write qualification: ports act only in RUN; address 0 is dropped when hardwired.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    clr_en = (state_q == CLEAR);
    wr0_en = (state_q == RUN) && bus.we0;
    wr1_en = (state_q == RUN) && bus.we1;
    if (ZERO_REG != 0) begin
      if (bus.waddr0 == '0) wr0_en = 1'b0;
      if (bus.waddr1 == '0) wr1_en = 1'b0;
    end
  end

  // Next-state logic for the CLEAR/RUN FSM, clear counter and ready flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(NREGS - 1)) state_d = RUN;
    end
    ready_d = (state_d == RUN);
  end

  // Scoreboard update: write clears first, then issue sets, so a set wins.
  always_comb begin
    // NOTE: blocking assignments here give the later statement priority within the same cycle.
    pending_d = pending_q;
    if (state_q == RUN) begin
      if (bus.we0)       pending_d[bus.waddr0] = 1'b0;
      if (bus.we1)       pending_d[bus.waddr1] = 1'b0;
      if (bus.iss_valid) pending_d[bus.iss_rd] = 1'b1;
    end
    if (ZERO_REG != 0) pending_d[0] = 1'b0;
  end

  // Control and scoreboard registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      pending_q <= pending_d;
    end
  end

  // Array storage: zeroed by the CLEAR sweep, then written by the two ports (port 1 last, so it wins).
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the CLEAR sweep zeroes it, which keeps the array RAM-friendly.
    if (clr_en) mem[cnt_q] <= '0;
    if (wr0_en) mem[bus.waddr0] <= bus.wdata0;
    if (wr1_en) mem[bus.waddr1] <= bus.wdata1;
  end

  // Combinational read lanes; zero in CLEAR and for hardwired register 0.
  always_comb begin
    bus.rdata = '0;
    for (int k = 0; k < NRP; k++) begin
      if (state_q == RUN) begin
        bus.rdata[k*XLEN +: XLEN] = mem[bus.raddr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (wr0_en && (bus.waddr0 == bus.raddr[k*AW +: AW]))
          bus.rdata[k*XLEN +: XLEN] = bus.wdata0;
        if (wr1_en && (bus.waddr1 == bus.raddr[k*AW +: AW]))
          bus.rdata[k*XLEN +: XLEN] = bus.wdata1;
`endif
        if ((ZERO_REG != 0) && (bus.raddr[k*AW +: AW] == '0))
          bus.rdata[k*XLEN +: XLEN] = '0;
      end
    end
  end

  assign bus.ready   = ready_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp (default parameters, NREGS=32, XLEN=32, NRP=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or shortly after a rising edge.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRP   = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.we0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.we1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
  endtask

  // One full clock: rising edge commits inputs, then back to the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called right after rst is released on a falling edge: counts rising edges
  // until ready rises (bounded), then realigns to the falling edge.
  task automatic count_clear(input string tag);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 64'(n), 64'd32);
    @(negedge clk);
  endtask

  function automatic logic [XLEN-1:0] lane(input int k);
    return bus.rdata[k*XLEN +: XLEN];
  endfunction

  logic [XLEN-1:0] exp_byp;

  initial begin
    idle();
    bus.raddr = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset state.
    check("rst_ready",   64'(bus.ready),   64'd0);
    check("rst_pending", 64'(bus.pending), 64'd0);
    check("rst_rdata",   64'(bus.rdata),   64'd0);

    // Release reset; try to write and issue during CLEAR (must be ignored).
    rst = 1'b0;
    bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'hCAFEF00D;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
    count_clear("clear_len_initial");
    idle();
    check("clear_pending_ignored", 64'(bus.pending), 64'd0);

    // Every register reads 0 after the sweep (lane 0), plus lane 1 spot check.
    for (int i = 0; i < NREGS; i++) begin
      bus.raddr = {5'd31, 5'(i)};
      #1;
      check($sformatf("zero_r%0d", i), 64'(lane(0)), 64'd0);
    end
    check("zero_lane1_r31", 64'(lane(1)), 64'd0);
    @(negedge clk);

    // Both ports to address 5: port 1 wins.
    bus.we0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'hDEADBEEF;
    bus.we1 = 1'b1; bus.waddr1 = 5'd5; bus.wdata1 = 32'h12345678;
    tick();
    idle();
    bus.raddr = {5'd0, 5'd5};
    #1;
    check("collide_p1_wins", 64'(lane(0)), 64'h12345678);

    // Distinct addresses on both ports, read on both lanes.
    @(negedge clk);
    bus.we0 = 1'b1; bus.waddr0 = 5'd9;  bus.wdata0 = 32'h11112222;
    bus.we1 = 1'b1; bus.waddr1 = 5'd10; bus.wdata1 = 32'h33334444;
    tick();
    idle();
    bus.raddr = {5'd10, 5'd9};
    #1;
    check("wr_p0_r9",  64'(lane(0)), 64'h11112222);
    check("wr_p1_r10", 64'(lane(1)), 64'h33334444);

    // Register 0 is hardwired: writes dropped, pending[0] never set.
    @(negedge clk);
    bus.we0 = 1'b1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hFFFFFFFF;
    bus.we1 = 1'b1; bus.waddr1 = 5'd0; bus.wdata1 = 32'hFFFFFFFF;
    tick();
    idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    tick();
    idle();
    bus.raddr = {5'd0, 5'd0};
    #1;
    check("r0_read_zero", 64'(bus.rdata), 64'd0);
    check("r0_pending",   64'(bus.pending), 64'd0);

    // Scoreboard: set, set-vs-clear (set wins), then lone write clears.
    @(negedge clk);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    tick();
    idle();
    check("pend_set7", 64'(bus.pending), 64'h0000_0080);
    bus.we0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h00000077;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    tick();
    idle();
    check("pend_set_wins", 64'(bus.pending), 64'h0000_0080);
    bus.we1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h00000777;
    tick();
    idle();
    check("pend_clear7", 64'(bus.pending), 64'd0);
    bus.raddr = {5'd0, 5'd7};
    #1;
    check("r7_value", 64'(lane(0)), 64'h00000777);

    // Same-cycle read of a register being written (register 3 still holds 0).
    @(negedge clk);
    bus.raddr = {5'd0, 5'd3};
    bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = 32'h0;
`endif
    check("same_cycle_r3", 64'(lane(0)), 64'(exp_byp));
    tick();
    idle();
    check("next_cycle_r3", 64'(lane(0)), 64'hA5A5A5A5);

    // Reset during RUN with pending bits set: immediate clear of control state.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd12;
    tick();
    idle();
    check("pend_set12", 64'(bus.pending), 64'h0000_1000);
    bus.raddr = {5'd10, 5'd9};
    rst = 1'b1;
    #1;
    check("run_rst_pending", 64'(bus.pending), 64'd0);
    check("run_rst_ready",   64'(bus.ready),   64'd0);
    check("run_rst_rdata",   64'(bus.rdata),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    count_clear("clear_len_after_run_rst");
    #1;
    check("r9_cleared",  64'(lane(0)), 64'd0);
    check("r10_cleared", 64'(lane(1)), 64'd0);

    // Reset in the middle of CLEAR (index 10 about to be written).
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("midclear_ready", 64'(bus.ready), 64'd0);
    rst = 1'b1;
    #1;
    check("midclear_rst_ready", 64'(bus.ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    count_clear("clear_len_after_midclear_rst");
    check("final_pending", 64'(bus.pending), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
